seq_detector: RTL and testbench

Parametrised, binary-encoded Moore sequence detector. Each enabled clock it samples serial input `w` and tracks the longest received suffix that matches a prefix of a programmable N-bit pattern. It asserts `z` while a full match is held, and counts matches in a saturating counter. It is the general-purpose successor to the fixed 3-bit-state detectors in the state-machine library: pattern, length and overlap mode are selectable, and the pattern can be reloaded at run time.

---
 rtl/seq_detector.sv | 105 ++++++++++
 tb/tb_seq_detector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// seq_detector
// Parametrised binary-encoded Moore sequence detector. Each enabled clock the
// serial bit w is sampled and State tracks the longest received suffix that
// equals a prefix of the programmable pattern (bit N-1 is received first).
// z is asserted while a full match is held, and match_cnt counts matches with
// saturation. The pattern can be reloaded at run time through load/pat_in.
//
// Ports:
//   clk       in  1      rising-edge clock
//   Reset     in  1      asynchronous active-low reset
//   en        in  1      sample enable; all state holds when low
//   w         in  1      serial data bit
//   load      in  1      synchronous pattern load strobe (beats en)
//   pat_in    in  N      new pattern captured on load
//   State     out SW     matched-prefix length, 0..N
//   z         out 1      match flag, decoded from State only
//   match_cnt out CNT_W  saturating match counter
module seq_detector #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             en,
  input  logic             w,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  output logic [SW-1:0]    State,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [SW-1:0] SMAX = SW'(N);

  logic [N-1:0]     pat_q, pat_d;
  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SW-1:0]    nextS;
  logic [SW-1:0]    sEff;
  logic [N-1:0]     pfx;
  logic [N:0]       cand;
  logic [N-1:0]     mask;

  // Next matched length by prefix comparison. The received history that
  // matters is exactly the matched prefix of length sEff, so the candidate
  // string is that prefix followed by w; the new state is the longest suffix
  // of the candidate that is also a pattern prefix. A full match in
  // non-overlap mode, or an out-of-range state, restarts from empty history.
  always_comb begin
    sEff  = state_q;
    nextS = '0;
    mask  = '0;
    if ((state_q > SMAX) || (!OVERLAP && (state_q == SMAX))) begin
      sEff = '0;
    end
    pfx  = pat_q >> (N - int'(sEff));
    cand = {pfx, w};
    for (int k = 1; k <= N; k++) begin
      mask = {mask[N-2:0], 1'b1};
      if ((k <= int'(sEff) + 1) &&
          ((cand[N-1:0] & mask) == (pat_q >> (N - k)))) begin
        nextS = SW'(k);
      end
    end
  end

  // Register updates: load beats enable; the counter only advances on an
  // enabled sample that lands on a full match, and sticks at all-ones.
  always_comb begin
    pat_d   = pat_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      pat_d   = pat_in;
      state_d = '0;
      cnt_d   = '0;
    end else if (en) begin
      state_d = nextS;
      if ((nextS == SMAX) && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pat_q   <= PATTERN;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign State     = state_q;
  assign z         = (state_q == SMAX);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector
// Self-checking bench for seq_detector. Three instances share one input
// stream: A (defaults, overlap), B (non-overlap), C (pattern 1111, 2-bit
// counter). A behavioural model keeps the raw bit history since the last
// restart and derives the matched length directly from its definition.
module tb_seq_detector;

  logic       clk;
  logic       Reset;
  logic       en;
  logic       w;
  logic       load;
  logic [3:0] patIn;

  logic [2:0] stateA, stateB, stateC;
  logic       zA, zB, zC;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;

  int checks;
  int errors;

  // Model state per instance: 0 = A, 1 = B, 2 = C.
  logic [63:0] mHist [3];
  int          mLen  [3];
  int          mS    [3];
  int          mCnt  [3];
  logic [3:0]  mPat  [3];
  bit          mOvl  [3] = '{1'b1, 1'b0, 1'b1};
  int          mMax  [3] = '{255, 255, 3};
  logic [3:0]  mRst  [3] = '{4'b1011, 4'b1011, 4'b1111};

  typedef struct {
    logic       w;
    logic       en;
    logic       load;
    logic [3:0] patIn;
    int         expStA;
    int         expCntA;
    int         expStB;
    int         expCntB;
  } vec_t;

  vec_t vecs [7];

  seq_detector dutA (
    .clk(clk), .Reset(Reset), .en(en), .w(w), .load(load), .pat_in(patIn),
    .State(stateA), .z(zA), .match_cnt(cntA)
  );

  seq_detector #(.OVERLAP(1'b0)) dutB (
    .clk(clk), .Reset(Reset), .en(en), .w(w), .load(load), .pat_in(patIn),
    .State(stateB), .z(zB), .match_cnt(cntB)
  );

  seq_detector #(.PATTERN(4'b1111), .CNT_W(2)) dutC (
    .clk(clk), .Reset(Reset), .en(en), .w(w), .load(load), .pat_in(patIn),
    .State(stateC), .z(zC), .match_cnt(cntC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Longest k <= 4 such that the last k received bits equal the first k
  // pattern bits (pattern bit 3 is the first one received).
  function automatic int suffixMatch(input logic [63:0] h, input int len, input logic [3:0] p);
    int best = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k <= len) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (h[j] != p[3 - (k - 1 - j)]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mHist[i] = '0;
      mLen[i]  = 0;
      mS[i]    = 0;
      mCnt[i]  = 0;
      mPat[i]  = mRst[i];
    end
  endtask

  task automatic modelStep(input logic bw, input logic ben, input logic bload, input logic [3:0] bpat);
    for (int i = 0; i < 3; i++) begin
      if (bload) begin
        mPat[i]  = bpat;
        mHist[i] = '0;
        mLen[i]  = 0;
        mS[i]    = 0;
        mCnt[i]  = 0;
      end else if (ben) begin
        if (!mOvl[i] && (mS[i] == 4)) begin
          mHist[i] = '0;
          mLen[i]  = 0;
        end
        mHist[i] = {mHist[i][62:0], bw};
        if (mLen[i] < 64) mLen[i]++;
        mS[i] = suffixMatch(mHist[i], mLen[i], mPat[i]);
        if ((mS[i] == 4) && (mCnt[i] < mMax[i])) mCnt[i]++;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("A.State", int'(stateA), mS[0]);
    checkOutput("A.z", int'(zA), int'(mS[0] == 4));
    checkOutput("A.cnt", int'(cntA), mCnt[0]);
    checkOutput("B.State", int'(stateB), mS[1]);
    checkOutput("B.z", int'(zB), int'(mS[1] == 4));
    checkOutput("B.cnt", int'(cntB), mCnt[1]);
    checkOutput("C.State", int'(stateC), mS[2]);
    checkOutput("C.z", int'(zC), int'(mS[2] == 4));
    checkOutput("C.cnt", int'(cntC), mCnt[2]);
  endtask

  // Drive one cycle of inputs between edges, let the edge sample them, then
  // advance the model and compare just after the edge.
  task automatic applyStimulus(input logic bw, input logic ben, input logic bload, input logic [3:0] bpat);
    w     = bw;
    en    = ben;
    load  = bload;
    patIn = bpat;
    @(posedge clk);
    #1;
    modelStep(bw, ben, bload, bpat);
    checkAll();
  endtask

  task automatic doReset();
    Reset = 1'b0;
    modelReset();
    #1;
    checkOutput("reset.State", int'(stateA), 0);
    checkOutput("reset.z", int'(zA), 0);
    checkOutput("reset.cnt", int'(cntA), 0);
    @(posedge clk);
    #1;
    Reset = 1'b1;
    load  = 1'b0;
    en    = 1'b1;
  endtask

  task automatic feedBits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(bits[i], 1'b1, 1'b0, 4'b0000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    en     = 1'b0;
    w      = 1'b0;
    load   = 1'b0;
    patIn  = 4'b0000;
    modelReset();
    #2;
    doReset();

    // Overlap and non-overlap on stream 1,0,1,1,0,1,1.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 4'h0, 1, 0, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 4'h0, 2, 0, 2, 0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4'h0, 3, 0, 3, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 4'h0, 4, 1, 4, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 4'h0, 2, 1, 0, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 4'h0, 3, 1, 1, 1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 4'h0, 4, 2, 1, 1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].w, vecs[i].en, vecs[i].load, vecs[i].patIn);
      checkOutput("tbl.A.State", int'(stateA), vecs[i].expStA);
      checkOutput("tbl.A.cnt", int'(cntA), vecs[i].expCntA);
      checkOutput("tbl.B.State", int'(stateB), vecs[i].expStB);
      checkOutput("tbl.B.cnt", int'(cntB), vecs[i].expCntB);
    end

    // Fallback 1,1,0,1,1 with a three-cycle enable gap after bit 3.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("fb.s1", int'(stateA), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("fb.s2", int'(stateA), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("fb.s3", int'(stateA), 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("fb.hold", int'(stateA), 2);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("fb.s4", int'(stateA), 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("fb.s5", int'(stateA), 4);

    // Load mid-sequence after one match, then detect the new pattern.
    doReset();
    feedBits(32'b101101, 6);
    checkOutput("ld.pre.State", int'(stateA), 3);
    checkOutput("ld.pre.cnt", int'(cntA), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0110);
    checkOutput("ld.State", int'(stateA), 0);
    checkOutput("ld.cnt", int'(cntA), 0);
    feedBits(32'b011, 3);
    checkOutput("ld.z3", int'(zA), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("ld.z4", int'(zA), 1);

    // Async reset with State=3 and five matches, then original pattern back.
    doReset();
    feedBits(32'b1011011011011011, 16);
    feedBits(32'b01, 2);
    checkOutput("ar.pre.State", int'(stateA), 3);
    checkOutput("ar.pre.cnt", int'(cntA), 5);
    doReset();
    feedBits(32'b1011, 4);
    checkOutput("ar.pat.z", int'(zA), 1);

    // Saturation on instance C: w held at 1 for ten cycles.
    doReset();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("sat.State", int'(stateC), (i < 4) ? i : 4);
      checkOutput("sat.cnt", int'(cntC), (i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3));
    end

    // Randomised phase against the model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) doReset();
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
